// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: operation controls, data and serial inputs in; register state out.
// No handshake: every control input is sampled on every rising clock edge.
interface universal_shift_reg_if #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
);
   logic [1:0]       mode;
   logic [WIDTH-1:0] d;
   logic             ser_in_msb;
   logic             ser_in_lsb;
   logic             rot;
   logic [WIDTH-1:0] q;
   logic             ser_out_r;
   logic             ser_out_l;
   logic [CW-1:0]    shift_cnt;
   logic             frame_done;

   modport master (
      output mode, d, ser_in_msb, ser_in_lsb, rot,
      input  q, ser_out_r, ser_out_l, shift_cnt, frame_done
   );

   modport slave (
      input  mode, d, ser_in_msb, ser_in_lsb, rot,
      output q, ser_out_r, ser_out_l, shift_cnt, frame_done
   );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with a frame counter
// pulsing frame_done every WIDTH shifts. Optional rotate feedback is enabled by defining USR_ROTATE_EN.
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input logic                  clk,
   input logic                  reset,
   universal_shift_reg_if.slave bus
);
   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] q_r;
   logic [CW-1:0]    cnt_r;
   logic             done_r;
   logic             msb_fill;
   logic             lsb_fill;
   logic             wrap;

`ifdef USR_ROTATE_EN
   // Rotation recirculates the bit falling off the far end instead of the serial input.
   always_comb begin
      msb_fill = bus.rot ? q_r[0]       : bus.ser_in_msb;
      lsb_fill = bus.rot ? q_r[WIDTH-1] : bus.ser_in_lsb;
   end
`else
   logic unused_rot;
   assign unused_rot = bus.rot;

   always_comb begin
      msb_fill = bus.ser_in_msb;
      lsb_fill = bus.ser_in_lsb;
   end
`endif

   assign wrap = (cnt_r == LAST_CNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         q_r    <= '0;
         cnt_r  <= '0;
         done_r <= 1'b0;
      end else begin
         case (bus.mode)
            MODE_HOLD: begin
               done_r <= 1'b0;
            end
            MODE_RIGHT, MODE_LEFT: begin
               if (bus.mode == MODE_RIGHT) q_r <= {msb_fill, q_r[WIDTH-1:1]};
               else                        q_r <= {q_r[WIDTH-2:0], lsb_fill};
               // Both directions share one frame count.
               cnt_r  <= wrap ? '0 : cnt_r + 1'b1;
               done_r <= wrap;
            end
            MODE_LOAD: begin
               q_r    <= bus.d;
               cnt_r  <= '0;
               done_r <= 1'b0;
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.q          = q_r;
   assign bus.shift_cnt  = cnt_r;
   assign bus.frame_done = done_r;
   assign bus.ser_out_r  = q_r[0];
   assign bus.ser_out_l  = q_r[WIDTH-1];
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
- REQ-001: Parameter WIDTH, default 8, register width in bits; legal range 2..64.
- REQ-002: Parameter CW, default $clog2(WIDTH)+1, shift-counter width; derived from WIDTH and not overridden.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- REQ-006: d  input  WIDTH  parallel load data.
- REQ-007: ser_in_msb  input  1  serial bit entering q[WIDTH-1] on shift right.
- REQ-008: ser_in_lsb  input  1  serial bit entering q[0] on shift left.
- REQ-009: rot  input  1  rotate request; always present; effect defined by REQ-027.
- REQ-010: q  output  WIDTH  registered register contents.
- REQ-011: ser_out_r  output  1  combinational, equal to q[0].
- REQ-012: ser_out_l  output  1  combinational, equal to q[WIDTH-1].
- REQ-013: shift_cnt  output  CW  registered count of shifts since last load, reset or frame wrap.
- REQ-014: frame_done  output  1  registered one-cycle pulse marking completion of WIDTH shifts.

Function
- REQ-015: mode 00: q and shift_cnt hold; frame_done is 0 in the following cycle.
- REQ-016: mode 01: q <= {ser_in_msb, q[WIDTH-1:1]}.
- REQ-017: mode 10: q <= {q[WIDTH-2:0], ser_in_lsb}.
- REQ-018: mode 11: q <= d; shift_cnt <= 0; frame_done <= 0.
- REQ-019: Each shift (mode 01 or 10) increments shift_cnt by 1.
- REQ-020: When a shift occurs with shift_cnt == WIDTH-1, shift_cnt wraps to 0 and frame_done is 1 for exactly the next cycle.
- REQ-021: frame_done is 0 in every cycle not covered by REQ-020.
- REQ-022: Direction changes between 01 and 10 do not clear shift_cnt; mixed-direction shifts count toward the same frame.
- REQ-023: A load in the cycle after a wrap clears frame_done only from that edge on; the pulse already asserted completes its cycle.
- REQ-024: Latency: q, shift_cnt and frame_done reflect an operation one clock edge after it is sampled; ser_out_l and ser_out_r follow q with no additional delay.

Reset
- REQ-025: With reset high at a rising edge: q = 0, shift_cnt = 0, frame_done = 0, regardless of mode, d, rot or serial inputs.
- REQ-026: Reset mid-frame discards the partial count; the next frame_done requires WIDTH further shifts after reset deasserts.

Configuration
- REQ-027: Macro USR_ROTATE_EN defined: rot = 1 during mode 01 feeds q[0] into q[WIDTH-1] in place of ser_in_msb; rot = 1 during mode 10 feeds q[WIDTH-1] into q[0] in place of ser_in_lsb. Shift counting is unchanged.
- REQ-028: Macro USR_ROTATE_EN undefined: rot is ignored and the serial inputs are always used.

Verification (WIDTH = 8)
- REQ-029: reset = 1 for 2 edges with mode = 11, d = 8'hA5 -> q = 8'h00, shift_cnt = 0, frame_done = 0.
- REQ-030: Load 8'hA5, then mode 01 with ser_in_msb = 0 for 8 edges -> ser_out_r before each edge is 1,0,1,0,0,1,0,1; q = 8'h00 afterwards; frame_done = 1 for only the cycle after the 8th edge; shift_cnt = 0.
- REQ-031: From q = 0, mode 10 with ser_in_lsb = 1 for 3 edges -> q = 8'h07, shift_cnt = 3, frame_done = 0.
- REQ-032: Load 8'h81, then mode 10 with rot = 1 and ser_in_lsb = 0 for 1 edge -> q = 8'h03 with USR_ROTATE_EN defined; q = 8'h02 without it.
- REQ-033: After 4 shifts, assert reset for 1 edge, then shift 4 times -> shift_cnt = 4 and frame_done never asserts; 4 more shifts -> frame_done pulses once.
- REQ-034: 5 shifts, then load 8'h3C, then 7 shifts -> no frame_done and shift_cnt = 7; 1 more shift -> frame_done pulses.
